// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and iterative shift-add mul / restoring div
module alu_seq #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   operand1,
    input  logic [N-1:0]   operand2,
    input  logic [2:0]     operation,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] alu_out,
    output logic           zero,
    output logic           carry,
    output logic           div_by_zero
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_ADD = 3'b000, OP_AND = 3'b001, OP_SUB = 3'b010, OP_OR  = 3'b011,
                           OP_XOR = 3'b100, OP_MUL = 3'b101, OP_DIV = 3'b110, OP_MIN = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;

    // acc_q/lo_q form one 2N-bit working register: product for mul, {remainder, quotient} for div
    logic [N-1:0]   acc_q, acc_d, lo_q, lo_d, b_q, b_d;
    logic           is_div_q, is_div_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] res_q, res_d;
    logic           zero_q, zero_d, carry_q, carry_d, dbz_q, dbz_d;

    logic [N:0]     add_sum, sub_diff, mul_sum, div_shift, div_trial;
    logic           div_ge;
    logic [N-1:0]   acc_step, lo_step;
    logic [2*N-1:0] single_res;
    logic           single_carry, single_dbz;

    assign add_sum   = {1'b0, operand1} + {1'b0, operand2};
    assign sub_diff  = {1'b0, operand1} - {1'b0, operand2};
    assign mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? b_q : {N{1'b0}})};
    assign div_shift = {acc_q, lo_q[N-1]};
    assign div_trial = div_shift - {1'b0, b_q};
    // The partial remainder stays below the divisor, so bit N of the trial is a clean borrow
    assign div_ge    = ~div_trial[N];

    always_comb begin
        acc_step = mul_sum[N:1];
        lo_step  = {mul_sum[0], lo_q[N-1:1]};
        if (is_div_q) begin
            acc_step = div_ge ? div_trial[N-1:0] : div_shift[N-1:0];
            lo_step  = {lo_q[N-2:0], div_ge};
        end
    end

    always_comb begin
        single_res   = '0;
        single_carry = 1'b0;
        single_dbz   = 1'b0;
        case (operation)
            OP_ADD: begin
                single_res   = {{(N-1){1'b0}}, add_sum};
                single_carry = add_sum[N];
            end
            OP_SUB: begin
                single_res   = {{N{1'b0}}, sub_diff[N-1:0]};
                single_carry = sub_diff[N];
            end
            OP_AND: single_res = {{N{1'b0}}, operand1 & operand2};
            OP_OR:  single_res = {{N{1'b0}}, operand1 | operand2};
            OP_XOR: single_res = {{N{1'b0}}, operand1 ^ operand2};
            OP_MIN: single_res = {{N{1'b0}}, (operand1 < operand2) ? operand1 : operand2};
            OP_DIV: begin
                single_res = {operand1, {N{1'b1}}};
                single_dbz = 1'b1;
            end
            default: single_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (operation == OP_MUL || (operation == OP_DIV && operand2 != '0)) begin
                        acc_d    = '0;
                        lo_d     = operand1;
                        b_d      = operand2;
                        is_div_d = (operation == OP_DIV);
                        cnt_d    = '0;
                        state_d  = BUSY;
                    end else begin
                        res_d   = single_res;
                        zero_d  = (single_res == '0);
                        carry_d = single_carry;
                        dbz_d   = single_dbz;
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                acc_d = acc_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    res_d   = {acc_step, lo_step};
                    zero_d  = ({acc_step, lo_step} == '0);
                    carry_d = 1'b0;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign alu_out     = res_q;
    assign zero        = zero_q;
    assign carry       = carry_q;
    assign div_by_zero = dbz_q;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have a parameter N, default 16, giving the operand width; N SHALL be 2 or more.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  the operation on operand1, operand2 and operation is presented.
REQ-006 in_ready  output  1  the block can accept an operation this cycle.
REQ-007 operand1, operand2  input  N each  unsigned operands.
REQ-008 operation  input  3  opcode: 000 add, 001 and, 010 sub, 011 or, 100 xor, 101 mul, 110 div, 111 min.
REQ-009 out_valid  output  1  alu_out and the flags hold a completed result.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 alu_out  output  2N  registered result.
REQ-012 zero  output  1  set when alu_out is all zeros.
REQ-013 carry  output  1  add carry-out, or sub borrow.
REQ-014 div_by_zero  output  1  set when a div had operand2 equal to 0.

Function
REQ-015 The state machine SHALL have three states: IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 An operation is accepted when in_valid and in_ready are both 1; the operands and opcode SHALL be captured at that point.
REQ-018 Single-cycle ops (add, and, sub, or, xor, min, and div with operand2 = 0) SHALL go IDLE to DONE; out_valid SHALL rise 1 cycle after accept.
REQ-019 mul and div with a nonzero divisor SHALL go IDLE to BUSY for exactly N cycles, then to DONE; out_valid SHALL rise N+1 cycles after accept.
REQ-020 mul SHALL be iterative shift-add, one bit per cycle; alu_out SHALL be the full 2N-bit unsigned product.
REQ-021 div SHALL be iterative restoring division, one bit per cycle; alu_out[N-1:0] SHALL be the quotient and alu_out[2N-1:N] the remainder.
REQ-022 div with operand2 = 0 SHALL set alu_out[N-1:0] to all ones and alu_out[2N-1:N] to operand1, with div_by_zero = 1.
REQ-023 add SHALL place the N+1-bit sum in alu_out[N:0]; carry SHALL equal bit N; the upper bits SHALL be 0.
REQ-024 sub SHALL place operand1 - operand2 modulo 2^N in alu_out[N-1:0]; carry SHALL be 1 when operand1 < operand2; the upper bits SHALL be 0.
REQ-025 and, or, xor and min (unsigned smaller operand) SHALL be zero-extended into alu_out; carry SHALL be 0.
REQ-026 div_by_zero SHALL be 0 for every result other than div with operand2 = 0.
REQ-027 In DONE, alu_out and all flags SHALL hold stable until out_valid and out_ready are both 1.
REQ-028 On that handshake the block SHALL return to IDLE and clear out_valid at the next edge.
REQ-029 No new operation SHALL be accepted in the handshake cycle; the earliest next accept is the cycle after.
REQ-030 in_valid and the operand inputs SHALL be ignored while in BUSY or DONE.
REQ-031 out_ready SHALL be ignored while out_valid is 0.

Reset
REQ-032 While reset is 1 at a clock edge, the state SHALL become IDLE, and out_valid, alu_out, zero, carry and div_by_zero SHALL be 0; in_ready SHALL be 1 from the following cycle.
REQ-033 Reset asserted in BUSY or DONE SHALL abort the operation and discard its result, with no out_valid pulse.
REQ-034 Reset SHALL take priority over an accept or a handshake in the same cycle.

Verification (N=16)
REQ-035 Add 0xFFFF + 0x0001 -> one cycle later: alu_out = 0x0001_0000, carry = 1, zero = 0.
REQ-036 Sub 0x0003 - 0x0003 -> alu_out = 0, zero = 1, carry = 0; sub 0x0001 - 0x0002 -> alu_out = 0x0000_FFFF, carry = 1.
REQ-037 Mul 0xFFFF x 0xFFFF -> out_valid exactly 17 cycles after accept, with alu_out = 0xFFFE_0001 and in_ready = 0 throughout.
REQ-038 Div 100 / 7 -> at 17 cycles: alu_out = 0x0002_000E; div 0x1234 / 0 -> at 1 cycle: alu_out = 0x1234_FFFF, div_by_zero = 1.
REQ-039 Min 0x0005 vs 0x0003 with out_ready held 0 for 3 cycles -> alu_out = 0x0003 holds stable with out_valid = 1 and in_ready = 0; after the handshake, the next in_valid is accepted one cycle later.
REQ-040 Reset pulsed on cycle 5 of a mul -> the next cycle shows IDLE, in_ready = 1, out_valid = 0, alu_out = 0, and no result is ever delivered.
